fp16_dot_accum: RTL and testbench

//  Streaming FP16 accumulator sitting directly downstream of the FP16 multiplier array, feeding channel sums to activation.

---
 rtl/fp16_pkg.sv | 19 +
 rtl/fp16_dot_accum_if.sv | 28 ++
 rtl/addfp16.sv | 68 ++++++
 rtl/fp16_dot_accum.sv | 123 ++++++++++++
 tb/tb_fp16_dot_accum.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/fp16_pkg.sv
// Shared FP16 types, constants and helpers for the multiplier, accumulator and activation stages.
package fp16_pkg;

   typedef logic [15:0] fp16_t;

   localparam logic [4:0] FP16_EXP_SPECIAL = 5'h1F;
   localparam fp16_t      FP16_ZERO        = 16'h0000;
   localparam fp16_t      FP16_ONE         = 16'h3C00;
   localparam fp16_t      FP16_QNAN        = 16'h7E00;

   function automatic logic fp16_is_special(input fp16_t v);
      return v[14:10] == FP16_EXP_SPECIAL;
   endfunction

   function automatic logic fp16_is_nan(input fp16_t v);
      return fp16_is_special(v) && (v[9:0] != 10'd0);
   endfunction

endpackage

// File: rtl/fp16_dot_accum_if.sv
// Beat input and result output channels of the FP16 accumulator.
interface fp16_dot_accum_if #(
   parameter int unsigned CNT_W = 9
);
   import fp16_pkg::*;

   logic             in_valid;
   logic             in_ready;
   fp16_t            in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   fp16_t            out_data;
   logic [CNT_W-1:0] out_count;
   logic             out_ovf;
   logic             out_spec;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_count, out_ovf, out_spec
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_count, out_ovf, out_spec
   );

endinterface

// File: rtl/addfp16.sv
// Combinational FP16 adder, round-to-nearest-even, denormal aware, IEEE Inf/NaN handling.
module addfp16
   import fp16_pkg::*;
(
   input  fp16_t a,
   input  fp16_t b,
   output fp16_t y
);

   fp16_t       x, z;
   logic [4:0]  ex, ez, d, lz, sh;
   logic [13:0] mx_e, mz_e, mz_sh, norm;
   logic [14:0] sum;
   logic [5:0]  e_n, e_r;
   logic [11:0] rnd;
   logic        sub, sticky;

   // x is the larger magnitude, so only z is ever right-aligned
   always_comb begin
      x      = (a[14:0] >= b[14:0]) ? a : b;
      z      = (a[14:0] >= b[14:0]) ? b : a;
      ex     = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
      ez     = (z[14:10] == 5'd0) ? 5'd1 : z[14:10];
      mx_e   = {(x[14:10] != 5'd0), x[9:0], 3'b000};
      mz_e   = {(z[14:10] != 5'd0), z[9:0], 3'b000};
      d      = ex - ez;
      sub    = x[15] ^ z[15];
      mz_sh  = 14'd0;
      sticky = |mz_e;
      if (d < 5'd14) begin
         mz_sh  = mz_e >> d;
         sticky = |(mz_e & ((14'd1 << d) - 14'd1));
      end
      mz_sh[0] = mz_sh[0] | sticky;
      sum = sub ? ({1'b0, mx_e} - {1'b0, mz_sh}) : ({1'b0, mx_e} + {1'b0, mz_sh});

      lz = 5'd14;
      for (int i = 0; i < 14; i++) begin
         if (sum[i]) lz = 5'(13 - i);
      end
      sh = (lz < ex - 5'd1) ? lz : ex - 5'd1;
      if (sum[14]) begin
         norm = {sum[14:2], sum[1] | sum[0]};
         e_n  = {1'b0, ex} + 6'd1;
      end else begin
         norm = sum[13:0] << sh;
         e_n  = {1'b0, ex} - {1'b0, sh};
      end

      rnd = {1'b0, norm[13:3]} + 12'(norm[2] & (norm[3] | norm[1] | norm[0]));
      e_r = rnd[11] ? e_n + 6'd1 : e_n;
      if (rnd[11]) rnd = rnd >> 1;

      y = {x[15], (rnd[10] ? e_r[4:0] : 5'd0), rnd[9:0]};
      if (e_r >= 6'd31) y = {x[15], FP16_EXP_SPECIAL, 10'd0};
      if (sum == 15'd0) y = {x[15] & z[15], 15'd0};

      if (fp16_is_nan(a) || fp16_is_nan(b) ||
          (fp16_is_special(a) && fp16_is_special(b) && sub)) begin
         y = FP16_QNAN;
      end else if (fp16_is_special(a)) begin
         y = a;
      end else if (fp16_is_special(b)) begin
         y = b;
      end
   end

endmodule

// File: rtl/fp16_dot_accum.sv
// Streaming FP16 accumulator: folds one partial product per beat into a running sum and
// presents sum, beat count and sticky flags on the batch's last beat until taken.
module fp16_dot_accum
   import fp16_pkg::*;
#(
   parameter  int unsigned MAX_LEN = 256,
   localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1)
) (
   input logic                clk,
   input logic                rst_n,
   input logic                clear,
   fp16_dot_accum_if.slave    bus
);

   typedef enum logic {ST_ACC, ST_HOLD} state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LEN);

   state_e           state_q, state_d;
   fp16_t            acc_q, acc_d, out_data_q, out_data_d, sum_c;
   logic [CNT_W-1:0] count_q, count_d, out_count_q, out_count_d;
   logic             first_q, first_d, ovf_q, ovf_d, spec_q, spec_d;
   logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
   logic             out_ovf_q, out_ovf_d, out_spec_q, out_spec_d;
   logic             accept_c, take_c;

   assign accept_c = in_ready_q & bus.in_valid;
   assign take_c   = out_valid_q & bus.out_ready;

   addfp16 u_add (.a(acc_q), .b(bus.in_data), .y(sum_c));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_ACC;
         acc_q       <= FP16_ZERO;
         count_q     <= '0;
         first_q     <= 1'b1;
         ovf_q       <= 1'b0;
         spec_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= FP16_ZERO;
         out_count_q <= '0;
         out_ovf_q   <= 1'b0;
         out_spec_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
         first_q     <= first_d;
         ovf_q       <= ovf_d;
         spec_q      <= spec_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_count_q <= out_count_d;
         out_ovf_q   <= out_ovf_d;
         out_spec_q  <= out_spec_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_ACC:  if (accept_c && bus.in_last) state_d = ST_HOLD;
         ST_HOLD: if (bus.out_ready) state_d = ST_ACC;
         default: state_d = ST_ACC;
      endcase
      if (clear) state_d = ST_ACC;
   end

   // Datapath and registered handshake outputs; clear wins over any same-cycle beat or take
   always_comb begin
      acc_d       = acc_q;
      count_d     = count_q;
      first_d     = first_q;
      ovf_d       = ovf_q;
      spec_d      = spec_q;
      out_data_d  = out_data_q;
      out_count_d = out_count_q;
      out_ovf_d   = out_ovf_q;
      out_spec_d  = out_spec_q;
      in_ready_d  = (state_d == ST_ACC);
      out_valid_d = (state_d == ST_HOLD);
      if (clear) begin
         acc_d       = FP16_ZERO;
         count_d     = '0;
         first_d     = 1'b1;
         ovf_d       = 1'b0;
         spec_d      = 1'b0;
         out_data_d  = FP16_ZERO;
         out_count_d = '0;
         out_ovf_d   = 1'b0;
         out_spec_d  = 1'b0;
      end else if (accept_c) begin
         acc_d   = first_q ? bus.in_data : sum_c;
         first_d = 1'b0;
         count_d = (count_q == CNT_MAX) ? CNT_MAX : count_q + CNT_W'(1);
         ovf_d   = ovf_q | (count_q == CNT_MAX);
         spec_d  = spec_q | fp16_is_special(bus.in_data);
         if (bus.in_last) begin
            out_data_d  = acc_d;
            out_count_d = count_d;
            out_ovf_d   = ovf_d;
            out_spec_d  = spec_d;
         end
      end else if (take_c) begin
         acc_d   = FP16_ZERO;
         count_d = '0;
         first_d = 1'b1;
         ovf_d   = 1'b0;
         spec_d  = 1'b0;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_count = out_count_q;
   assign bus.out_ovf   = out_ovf_q;
   assign bus.out_spec  = out_spec_q;

endmodule

// File: tb/tb_fp16_dot_accum.sv
// Directed bench for fp16_dot_accum: a default build and a MAX_LEN=4 build driven with identical stimulus.
module tb_fp16_dot_accum;
   import fp16_pkg::*;

   logic  clk = 1'b0;
   logic  rst_n = 1'b0;
   logic  clear = 1'b0;
   logic  in_valid = 1'b0;
   fp16_t in_data = 16'h0000;
   logic  in_last = 1'b0;
   logic  out_ready = 1'b0;

   int checks = 0;
   int errors = 0;

   fp16_dot_accum_if #(.CNT_W(9)) bus  ();
   fp16_dot_accum_if #(.CNT_W(3)) bus4 ();

   assign bus.in_valid   = in_valid;
   assign bus.in_data    = in_data;
   assign bus.in_last    = in_last;
   assign bus.out_ready  = out_ready;
   assign bus4.in_valid  = in_valid;
   assign bus4.in_data   = in_data;
   assign bus4.in_last   = in_last;
   assign bus4.out_ready = out_ready;

   fp16_dot_accum #(.MAX_LEN(256)) u_dut  (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus.slave));
   fp16_dot_accum #(.MAX_LEN(4))   u_dut4 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus4.slave));

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0][15:0] beats;
      int               n;
      fp16_t            exp_data;
      logic             exp_spec;
   } vec_t;

   vec_t vecs[10];

   function automatic vec_t mk(input int n, input fp16_t b0, input fp16_t b1, input fp16_t b2,
                               input fp16_t b3, input fp16_t ed, input logic es);
      vec_t v;
      v.beats    = {b3, b2, b1, b0};
      v.n        = n;
      v.exp_data = ed;
      v.exp_spec = es;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the beat was accepted
   task automatic send(input fp16_t d, input logic last);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) check("in_ready wait", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic take(input string tag, input fp16_t ed, input int ec, input logic eo,
                       input logic es, input int ec4, input logic eo4);
      int n = 0;
      while (!bus.out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, " valid"},  32'(bus.out_valid),  32'd1);
      check({tag, " data"},   32'(bus.out_data),   32'(ed));
      check({tag, " count"},  32'(bus.out_count),  32'(ec));
      check({tag, " ovf"},    32'(bus.out_ovf),    32'(eo));
      check({tag, " spec"},   32'(bus.out_spec),   32'(es));
      check({tag, " valid4"}, 32'(bus4.out_valid), 32'd1);
      check({tag, " data4"},  32'(bus4.out_data),  32'(ed));
      check({tag, " count4"}, 32'(bus4.out_count), 32'(ec4));
      check({tag, " ovf4"},   32'(bus4.out_ovf),   32'(eo4));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, " drop"},   32'(bus.out_valid),  32'd0);
      check({tag, " ready"},  32'(bus.in_ready),   32'd1);
   endtask

   initial begin
      vecs[0] = mk(1, 16'h3C00, 16'h0000, 16'h0000, 16'h0000, 16'h3C00, 1'b0);
      vecs[1] = mk(4, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h4400, 1'b0);
      vecs[2] = mk(2, 16'h4000, 16'h3800, 16'h0000, 16'h0000, 16'h4100, 1'b0);
      vecs[3] = mk(3, 16'h3C00, 16'h7C00, 16'h3C00, 16'h0000, 16'h7C00, 1'b1);
      vecs[4] = mk(1, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 1'b0);
      vecs[5] = mk(1, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 1'b0);
      vecs[6] = mk(2, 16'h3C00, 16'hBC00, 16'h0000, 16'h0000, 16'h0000, 1'b0);
      vecs[7] = mk(2, 16'h4200, 16'hBC00, 16'h0000, 16'h0000, 16'h4000, 1'b0);
      vecs[8] = mk(3, 16'h3C00, 16'h3C00, 16'h3C00, 16'h0000, 16'h4200, 1'b0);
      vecs[9] = mk(2, 16'hBC00, 16'hBC00, 16'h0000, 16'h0000, 16'hC000, 1'b0);

      repeat (2) @(negedge clk);
      check("reset out_valid", 32'(bus.out_valid), 32'd0);
      check("reset out_data",  32'(bus.out_data),  32'd0);
      check("reset out_count", 32'(bus.out_count), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post-reset in_ready", 32'(bus.in_ready), 32'd1);

      for (int i = 0; i < 10; i++) begin
         for (int j = 0; j < vecs[i].n; j++) send(vecs[i].beats[j], j == vecs[i].n - 1);
         take($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].n, 1'b0, vecs[i].exp_spec,
              vecs[i].n, 1'b0);
      end

      // Backpressure with a pending result and a waiting beat
      send(16'h4000, 1'b0);
      send(16'h4000, 1'b1);
      in_valid = 1'b1; in_data = 16'h3C00; in_last = 1'b1;
      for (int k = 0; k < 5; k++) begin
         check("bp in_ready",  32'(bus.in_ready),  32'd0);
         check("bp out_valid", 32'(bus.out_valid), 32'd1);
         check("bp out_data",  32'(bus.out_data),  32'h4400);
         check("bp out_count", 32'(bus.out_count), 32'd2);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("bp handshake valid", 32'(bus.out_valid), 32'd0);
      check("bp handshake ready", 32'(bus.in_ready),  32'd1);
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      take("bp next", 16'h3C00, 1, 1'b0, 1'b0, 1, 1'b0);

      // Overflow on the MAX_LEN=4 build, then a clean batch
      for (int k = 0; k < 5; k++) send(16'h3C00, k == 4);
      take("ovf", 16'h4500, 5, 1'b0, 1'b0, 4, 1'b1);
      send(16'h3C00, 1'b1);
      take("ovf after", 16'h3C00, 1, 1'b0, 1'b0, 1, 1'b0);

      // Clear mid-batch drops the same-cycle last beat
      send(16'h3C00, 1'b0);
      send(16'h3C00, 1'b0);
      clear = 1'b1; in_valid = 1'b1; in_data = 16'h3C00; in_last = 1'b1;
      @(negedge clk);
      clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      check("clear out_valid", 32'(bus.out_valid), 32'd0);
      check("clear out_data",  32'(bus.out_data),  32'd0);
      @(negedge clk);
      check("clear no result", 32'(bus.out_valid), 32'd0);
      send(16'h4000, 1'b1);
      take("after clear", 16'h4000, 1, 1'b0, 1'b0, 1, 1'b0);

      // Clear while holding a result
      send(16'h3800, 1'b1);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clear hold valid", 32'(bus.out_valid), 32'd0);
      check("clear hold count", 32'(bus.out_count), 32'd0);

      // Asynchronous reset mid-batch
      send(16'h3C00, 1'b0);
      send(16'h3C00, 1'b0);
      #2 rst_n = 1'b0;
      #1 check("rst mid count", 32'(bus.out_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      send(16'h3C00, 1'b1);
      take("after rst mid", 16'h3C00, 1, 1'b0, 1'b0, 1, 1'b0);

      // Asynchronous reset during HOLD
      send(16'h4000, 1'b1);
      check("pre-rst valid", 32'(bus.out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst hold valid", 32'(bus.out_valid), 32'd0);
      check("rst hold data",  32'(bus.out_data),  32'd0);
      check("rst hold count", 32'(bus.out_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(16'h3800, 1'b1);
      take("after rst hold", 16'h3800, 1, 1'b0, 1'b0, 1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
